alu_op_sequencer: RTL and testbench

- Issue side of the ALU result path. Accepts one ALU operation per valid/ready handshake and registers the operands.
- Drives the 4-bit result-select code into the ALU result mux. Waits a per-opcode latency, then captures the muxed result.
- Presents the result on a valid/ready output handshake.
- Detects divide/modulo by zero and illegal opcodes without exercising the datapath.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_lat_counter.sv | 27 ++
 rtl/alu_op_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: result-mux select codes, sequencer
// states and the per-opcode latency lookup.
package alu_pkg;

  localparam logic [3:0] SEL_SUB  = 4'd0;
  localparam logic [3:0] SEL_ADD  = 4'd1;
  localparam logic [3:0] SEL_MUL  = 4'd2;
  localparam logic [3:0] SEL_MOV  = 4'd3;
  localparam logic [3:0] SEL_COMP = 4'd4;
  localparam logic [3:0] SEL_DIV  = 4'd5;
  localparam logic [3:0] SEL_XOR  = 4'd6;
  localparam logic [3:0] SEL_AND  = 4'd7;
  localparam logic [3:0] SEL_NOT  = 4'd8;
  localparam logic [3:0] SEL_MOD  = 4'd9;
  localparam logic [3:0] SEL_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Cycles from select-valid until the mux output can be sampled.
  function automatic int op_lat(input logic [3:0] code, input int mul_lat, input int div_lat);
    case (code)
      SEL_MUL:          return mul_lat;
      SEL_DIV, SEL_MOD: return div_lat;
      default:          return 1;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] code);
    return (code > SEL_MOD);
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Down-counter that times the functional-unit latency between select and capture.
module alu_lat_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue side of the ALU result path: accept op, drive select, wait, capture, hand off.
// Optional macro ALU_SEQ_BACK2BACK_EN lets a new op be accepted during the result handshake.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N       = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [3:0]   op_code,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   sel,
  input  logic [N-1:0] res_in,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_err
);

  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL) + 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_alu_a;
  logic [N-1:0]  r_alu_b;
  logic [3:0]    r_sel;
  logic [N-1:0]  r_res_data;
  logic          r_res_err;

  logic          w_op_ready;
  logic          w_accept;
  logic          w_illegal;
  logic          w_divz;
  logic          w_err;
  logic          w_load;
  logic          w_dec;
  logic          w_zero;
  logic [CW-1:0] w_load_val;

`ifdef ALU_SEQ_BACK2BACK_EN
  assign w_op_ready = (r_state == IDLE) || ((r_state == HOLD) && res_ready);
`else
  assign w_op_ready = (r_state == IDLE);
`endif

  assign w_accept   = op_valid && w_op_ready;
  assign w_illegal  = is_illegal(op_code);
  assign w_divz     = ((op_code == SEL_DIV) || (op_code == SEL_MOD)) && (op_b == '0);
  assign w_err      = w_illegal || w_divz;
  assign w_load_val = CW'(op_lat(op_code, MUL_LAT, DIV_LAT) - 1);

  // An accept is only possible in IDLE or (with back-to-back) in a HOLD handshake,
  // so it overrides whatever the current state would otherwise do.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = IDLE;
      WAIT: begin
        if (w_zero) w_state_nxt = HOLD;
        else        w_dec       = 1'b1;
      end
      HOLD: if (res_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_accept) begin
      w_state_nxt = w_err ? HOLD : WAIT;
      w_load      = !w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_sel      <= SEL_NONE;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (w_err) begin
          r_res_data <= w_illegal ? {N{1'b0}} : {N{1'b1}};
          r_res_err  <= 1'b1;
          r_sel      <= SEL_NONE;
        end else begin
          r_alu_a <= op_a;
          r_alu_b <= op_b;
          r_sel   <= op_code;
        end
      end else if ((r_state == WAIT) && w_zero) begin
        r_res_data <= res_in;
        r_res_err  <= 1'b0;
      end else if ((r_state == HOLD) && res_ready) begin
        r_sel <= SEL_NONE;
      end
    end
  end

  alu_lat_counter #(.CW(CW)) u_lat (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  assign op_ready  = w_op_ready;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign sel       = r_sel;
  assign res_valid = (r_state == HOLD);
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer; the result mux is modelled with per-op latency.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int N       = 4;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;
`ifdef ALU_SEQ_BACK2BACK_EN
  localparam int PERIOD = 2;
`else
  localparam int PERIOD = 3;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid;
  logic         op_ready;
  logic [3:0]   op_code;
  logic [N-1:0] op_a, op_b;
  logic [N-1:0] alu_a, alu_b;
  logic [3:0]   sel;
  logic [N-1:0] res_in;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_err;

  typedef struct packed {
    logic [N-1:0] d;
    logic         e;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  alu_op_sequencer #(.N(N), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .alu_a(alu_a), .alu_b(alu_b), .sel(sel), .res_in(res_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Result mux: output is only correct once sel has been stable for the op's latency.
  logic [3:0]   prev_sel = SEL_NONE;
  int           age_reg = 0;
  int           w_age;
  logic [N-1:0] mux_f;
  always_comb w_age = (sel == prev_sel) ? age_reg + 1 : 1;
  always @(posedge clk) begin
    prev_sel <= sel;
    age_reg  <= w_age;
  end
  always_comb begin
    case (sel)
      SEL_SUB:  mux_f = alu_a - alu_b;
      SEL_ADD:  mux_f = alu_a + alu_b;
      SEL_MUL:  mux_f = N'(alu_a * alu_b);
      SEL_MOV:  mux_f = alu_a;
      SEL_COMP: mux_f = ~alu_a;
      SEL_DIV:  mux_f = (alu_b == '0) ? '1 : alu_a / alu_b;
      SEL_XOR:  mux_f = alu_a ^ alu_b;
      SEL_AND:  mux_f = alu_a & alu_b;
      SEL_NOT:  mux_f = ~alu_a;
      SEL_MOD:  mux_f = (alu_b == '0) ? '1 : alu_a % alu_b;
      default:  mux_f = '0;
    endcase
    res_in = (w_age >= op_lat(sel, MUL_LAT, DIV_LAT)) ? mux_f : '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      hs_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got data=%0h err=%0b expected no result", res_data, res_err);
      end else begin
        mon_e = sb.pop_front();
        check("res_data", 32'(res_data), 32'(mon_e.d));
        check("res_err", 32'(res_err), 32'(mon_e.e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] code, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] ed, input logic ee, input bit push);
    int i;
    op_code  = code;
    op_a     = a;
    op_b     = b;
    op_valid = 1'b1;
    for (i = 0; i < 20 && !op_ready; i++) tick();
    if (!op_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got op_ready=0 expected 1 within 20 cycles");
    end
    if (push) sb.push_back('{d: ed, e: ee});
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_hold(input string name);
    int i;
    for (i = 0; i < 20 && !res_valid; i++) tick();
    if (!res_valid) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got res_valid=0 expected 1 within 20 cycles", name);
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

  logic [3:0]   s_code[4] = '{SEL_AND, SEL_NOT, SEL_COMP, SEL_ADD};
  logic [N-1:0] s_a[4]    = '{4'hC, 4'h3, 4'h5, 4'h7};
  logic [N-1:0] s_b[4]    = '{4'hA, 4'h0, 4'h0, 4'h8};
  logic [N-1:0] s_exp[4]  = '{4'h8, 4'hC, 4'hA, 4'hF};

  initial begin
    int idx;
    rst = 1'b1; op_valid = 1'b0; res_ready = 1'b0; op_code = '0; op_a = '0; op_b = '0;
    repeat (2) tick();
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_sel", 32'(sel), 32'hF);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    rst = 1'b0;
    tick();

    // add 3+4
    issue(SEL_ADD, 4'd3, 4'd4, 4'd7, 1'b0, 1'b1);
    check("add_sel_t1", 32'(sel), 32'(SEL_ADD));
    check("add_ready_t1", 32'(op_ready), 32'd0);
    check("add_valid_t1", 32'(res_valid), 32'd0);
    tick();
    check("add_valid_t2", 32'(res_valid), 32'd1);
    check("add_ready_t2", 32'(op_ready), 32'd0);
    handshake();
    check("add_sel_idle", 32'(sel), 32'hF);
    check("add_ready_idle", 32'(op_ready), 32'd1);

    // mul 3*5, two-cycle latency
    issue(SEL_MUL, 4'd3, 4'd5, 4'hF, 1'b0, 1'b1);
    check("mul_sel_t1", 32'(sel), 32'(SEL_MUL));
    check("mul_valid_t1", 32'(res_valid), 32'd0);
    tick();
    check("mul_sel_t2", 32'(sel), 32'(SEL_MUL));
    check("mul_valid_t2", 32'(res_valid), 32'd0);
    tick();
    check("mul_valid_t3", 32'(res_valid), 32'd1);
    handshake();

    // divide by zero and illegal opcode
    issue(SEL_DIV, 4'd9, 4'd0, 4'hF, 1'b1, 1'b1);
    check("divz_valid_t1", 32'(res_valid), 32'd1);
    check("divz_sel", 32'(sel), 32'hF);
    handshake();
    issue(4'd12, 4'd1, 4'd2, 4'h0, 1'b1, 1'b1);
    check("illegal_valid_t1", 32'(res_valid), 32'd1);
    check("illegal_sel", 32'(sel), 32'hF);
    handshake();

    // backpressure with a pending op held on the input
    issue(SEL_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b1);
    op_code = SEL_SUB; op_a = 4'd5; op_b = 4'd3; op_valid = 1'b1;
    wait_hold("bp");
    for (int k = 0; k < 5; k++) begin
      check("bp_res_data", 32'(res_data), 32'd3);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_op_ready", 32'(op_ready), 32'd0);
      check("bp_alu_a", 32'(alu_a), 32'd1);
      tick();
    end
    res_ready = 1'b1;
    sb.push_back('{d: 4'd2, e: 1'b0});
    tick();
    res_ready = 1'b0;
`ifdef ALU_SEQ_BACK2BACK_EN
    check("bp_b2b_sel", 32'(sel), 32'(SEL_SUB));
    check("bp_b2b_valid", 32'(res_valid), 32'd0);
`else
    check("bp_bubble_ready", 32'(op_ready), 32'd1);
    check("bp_bubble_sel", 32'(sel), 32'hF);
    tick();
    check("bp_next_sel", 32'(sel), 32'(SEL_SUB));
`endif
    op_valid = 1'b0;
    wait_hold("bp_sub");
    handshake();

    // reset wins over a result handshake in HOLD
    issue(SEL_ADD, 4'd2, 4'd2, 4'd4, 1'b0, 1'b0);
    wait_hold("rsthold");
    rst = 1'b1; res_ready = 1'b1;
    tick();
    rst = 1'b0; res_ready = 1'b0;
    check("rsthold_valid", 32'(res_valid), 32'd0);
    check("rsthold_data", 32'(res_data), 32'd0);
    check("rsthold_ready", 32'(op_ready), 32'd1);

    // reset during the WAIT of a mod
    issue(SEL_MOD, 4'd7, 4'd3, 4'd1, 1'b0, 1'b0);
    tick();
    check("rstwait_sel_before", 32'(sel), 32'(SEL_MOD));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstwait_ready", 32'(op_ready), 32'd1);
    check("rstwait_valid", 32'(res_valid), 32'd0);
    check("rstwait_sel", 32'(sel), 32'hF);
    check("rstwait_alu_a", 32'(alu_a), 32'd0);
    issue(SEL_XOR, 4'hA, 4'h5, 4'hF, 1'b0, 1'b1);
    wait_hold("xor");
    handshake();

    // streaming single-cycle ops with the consumer always ready
    hs_cyc.delete();
    res_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 40 && hs_cyc.size() < 4; c++) begin
`ifdef ALU_SEQ_BACK2BACK_EN
      if (res_valid) check("stream_hold_ready", 32'(op_ready), 32'd1);
`endif
      if (op_ready && idx < 4) begin
        op_code = s_code[idx]; op_a = s_a[idx]; op_b = s_b[idx]; op_valid = 1'b1;
        sb.push_back('{d: s_exp[idx], e: 1'b0});
        idx++;
      end else begin
        op_valid = 1'b0;
      end
      tick();
    end
    op_valid = 1'b0;
    res_ready = 1'b0;
    check("stream_count", 32'(hs_cyc.size()), 32'd4);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("stream_period", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(PERIOD));

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
